// File: rtl/l2_data_responder.sv
// rtl/l2_data_responder.sv - L2 data responder: word write/read with fixed access latency.
// Optional L2_ADDR_RANGE_CHECK_EN: drop out-of-range writes, return 32'hDEAD_BEEF on out-of-range reads.
module l2_data_responder #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int L2_BUS_WIDTH   = 32,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int ACCESS_LATENCY = 4
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  output logic                      WRITE_TO_L2_READY_DATA,
  input  logic                      WRITE_TO_L2_VALID_DATA,
  input  logic [ADDRESS_WIDTH-3:0]  WRITE_ADDR_TO_L2_DATA,
  input  logic [L2_BUS_WIDTH-1:0]   DATA_TO_L2_DATA,
  input  logic                      WRITE_CONTROL_TO_L2_DATA,
  output logic                      WRITE_COMPLETE_DATA,
  output logic                      READ_ADDR_TO_L2_READY_DATA,
  input  logic                      READ_ADDR_TO_L2_VALID_DATA,
  input  logic [ADDRESS_WIDTH-3:0]  READ_ADDR_TO_L2_DATA,
  input  logic                      DATA_FROM_L2_READY_DATA,
  output logic                      DATA_FROM_L2_VALID_DATA,
  output logic [L2_BUS_WIDTH-1:0]   DATA_FROM_L2_DATA
);

  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_DONE, RD_WAIT, RD_RESP} state_t;

  state_t                      state;
  logic [7:0]                  lat_cnt;
  logic [ADDRESS_WIDTH-3:0]    req_addr;
  logic [L2_BUS_WIDTH-1:0]     wr_data;
  logic                        wr_ctrl;
  logic [L2_BUS_WIDTH-1:0]     mem [2**MEM_DEPTH_LOG2];
  logic [MEM_DEPTH_LOG2-1:0]   mem_idx;
  logic                        addr_in_range;
  logic                        wait_done;
  logic                        mem_we;

  assign mem_idx   = req_addr[MEM_DEPTH_LOG2-1:0];
  assign wait_done = (lat_cnt == 8'd0);

`ifdef L2_ADDR_RANGE_CHECK_EN
  assign addr_in_range = ((req_addr >> MEM_DEPTH_LOG2) == '0);
`else
  // Upper word-address bits alias into memory.
  logic unused_addr_hi;
  assign addr_in_range  = 1'b1;
  assign unused_addr_hi = ^(req_addr >> MEM_DEPTH_LOG2);
`endif

  assign WRITE_TO_L2_READY_DATA     = (state == IDLE) && RSTN;
  assign READ_ADDR_TO_L2_READY_DATA = (state == IDLE) && RSTN;

  assign mem_we = RSTN && (state == WR_WAIT) && wait_done && wr_ctrl && addr_in_range;

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_idx] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state                   <= IDLE;
      lat_cnt                 <= 8'd0;
      req_addr                <= '0;
      wr_data                 <= '0;
      wr_ctrl                 <= 1'b0;
      WRITE_COMPLETE_DATA     <= 1'b0;
      DATA_FROM_L2_VALID_DATA <= 1'b0;
      DATA_FROM_L2_DATA       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Write wins when both channels are valid; the read stays pending.
          if (WRITE_TO_L2_VALID_DATA) begin
            req_addr <= WRITE_ADDR_TO_L2_DATA;
            wr_data  <= DATA_TO_L2_DATA;
            wr_ctrl  <= WRITE_CONTROL_TO_L2_DATA;
            lat_cnt  <= 8'(ACCESS_LATENCY - 1);
            state    <= WR_WAIT;
          end else if (READ_ADDR_TO_L2_VALID_DATA) begin
            req_addr <= READ_ADDR_TO_L2_DATA;
            lat_cnt  <= 8'(ACCESS_LATENCY - 1);
            state    <= RD_WAIT;
          end
        end
        WR_WAIT: begin
          if (wait_done) begin
            WRITE_COMPLETE_DATA <= 1'b1;
            state               <= WR_DONE;
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        WR_DONE: begin
          WRITE_COMPLETE_DATA <= 1'b0;
          state               <= IDLE;
        end
        RD_WAIT: begin
          if (wait_done) begin
            DATA_FROM_L2_VALID_DATA <= 1'b1;
            DATA_FROM_L2_DATA       <= addr_in_range ? mem[mem_idx]
                                                     : L2_BUS_WIDTH'(32'hDEAD_BEEF);
            state                   <= RD_RESP;
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        RD_RESP: begin
          if (DATA_FROM_L2_READY_DATA) begin
            DATA_FROM_L2_VALID_DATA <= 1'b0;
            DATA_FROM_L2_DATA       <= '0;
            state                   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_data_responder.sv
// tb/tb_l2_data_responder.sv - Self-checking bench for l2_data_responder against a word-memory model.
module tb_l2_data_responder;
  localparam int L   = 4;
  localparam int AW  = 32;
  localparam int BW  = 32;
  localparam int DLG = 10;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          w_ready, w_valid, w_ctrl, w_complete;
  logic [AW-3:0] w_addr, r_addr;
  logic [BW-1:0] w_data, d_data;
  logic          r_ready, r_valid, d_ready, d_valid;

  int n_cmp = 0;
  int n_err = 0;

  logic [BW-1:0] model_mem [int];
  logic [AW-3:0] written_q [$];

  always #5 CLK = ~CLK;

  l2_data_responder #(
    .ADDRESS_WIDTH(AW), .L2_BUS_WIDTH(BW), .MEM_DEPTH_LOG2(DLG), .ACCESS_LATENCY(L)
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .WRITE_TO_L2_READY_DATA(w_ready), .WRITE_TO_L2_VALID_DATA(w_valid),
    .WRITE_ADDR_TO_L2_DATA(w_addr), .DATA_TO_L2_DATA(w_data),
    .WRITE_CONTROL_TO_L2_DATA(w_ctrl), .WRITE_COMPLETE_DATA(w_complete),
    .READ_ADDR_TO_L2_READY_DATA(r_ready), .READ_ADDR_TO_L2_VALID_DATA(r_valid),
    .READ_ADDR_TO_L2_DATA(r_addr), .DATA_FROM_L2_READY_DATA(d_ready),
    .DATA_FROM_L2_VALID_DATA(d_valid), .DATA_FROM_L2_DATA(d_data)
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_read(input logic [AW-3:0] a);
    int idx;
`ifdef L2_ADDR_RANGE_CHECK_EN
    if ((a >> DLG) != 0) return 32'hDEAD_BEEF;
`endif
    idx = int'(a % (1 << DLG));
    return model_mem.exists(idx) ? model_mem[idx] : '0;
  endfunction

  task automatic model_write(input logic [AW-3:0] a, input logic [BW-1:0] d, input logic c);
`ifdef L2_ADDR_RANGE_CHECK_EN
    if ((a >> DLG) != 0) return;
`endif
    if (c) model_mem[int'(a % (1 << DLG))] = d;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!w_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, {31'd0, w_ready}, 1);
  endtask

  task automatic do_write(input logic [AW-3:0] a, input logic [BW-1:0] d, input logic c);
    w_valid = 1'b1; w_addr = a; w_data = d; w_ctrl = c;
    wait_ready("wr_ready_wait");
    @(posedge CLK);
    @(negedge CLK);
    w_valid = 1'b0;
    chk("wr_ready_after_acc", {31'd0, w_ready}, 0);
    for (int i = 1; i <= L; i++) begin
      @(negedge CLK);
      chk("wr_complete_timing", {31'd0, w_complete}, (i == L) ? 1 : 0);
      chk("rd_ready_during_wr", {31'd0, r_ready}, 0);
    end
    @(negedge CLK);
    chk("wr_pulse_end", {31'd0, w_complete}, 0);
    chk("wr_ready_back", {31'd0, w_ready}, 1);
    model_write(a, d, c);
    written_q.push_back(a);
  endtask

  task automatic do_read(input logic [AW-3:0] a, input int hold);
    logic [BW-1:0] expv;
    expv = exp_read(a);
    r_valid = 1'b1; r_addr = a; d_ready = (hold == 0);
    wait_ready("rd_ready_wait");
    @(posedge CLK);
    @(negedge CLK);
    r_valid = 1'b0;
    chk("rd_valid_after_acc", {31'd0, d_valid}, 0);
    for (int i = 1; i <= L; i++) begin
      @(negedge CLK);
      chk("rd_valid_timing", {31'd0, d_valid}, (i == L) ? 1 : 0);
      if (i == L) chk("rd_data", d_data, expv);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk("rd_hold_valid", {31'd0, d_valid}, 1);
      chk("rd_hold_data", d_data, expv);
    end
    d_ready = 1'b1;
    @(negedge CLK);
    chk("rd_valid_drop", {31'd0, d_valid}, 0);
    chk("rd_data_clear", d_data, 0);
    chk("rd_ready_back", {31'd0, r_ready}, 1);
    d_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-3:0] a;
    RSTN = 1'b0; w_valid = 0; w_addr = '0; w_data = '0; w_ctrl = 0;
    r_valid = 0; r_addr = '0; d_ready = 0;
    repeat (3) @(negedge CLK);
    chk("rst_w_ready", {31'd0, w_ready}, 0);
    chk("rst_r_ready", {31'd0, r_ready}, 0);
    chk("rst_complete", {31'd0, w_complete}, 0);
    chk("rst_valid", {31'd0, d_valid}, 0);
    chk("rst_data", d_data, 0);
    RSTN = 1'b1;
    @(negedge CLK);
    chk("idle_ready", {31'd0, w_ready}, 1);

    do_write(30'h10, 32'hA5A5_0001, 1'b1);
    do_read(30'h10, 0);

    // Simultaneous write and read to the same word: write first.
    r_valid = 1'b1; r_addr = 30'h20;
    do_write(30'h20, 32'h1234_5678, 1'b1);
    do_read(30'h20, 0);

    do_read(30'h10, 6);

    do_write(30'h10, 32'hFFFF_0000, 1'b0);
    do_read(30'h10, 0);

    // Reset two cycles into a write must abort it.
    do_write(30'h30, 32'h0000_3030, 1'b1);
    w_valid = 1'b1; w_addr = 30'h30; w_data = 32'hBAD0_3030; w_ctrl = 1'b1;
    wait_ready("abort_ready_wait");
    @(posedge CLK);
    @(negedge CLK);
    w_valid = 1'b0;
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    chk("abort_w_ready", {31'd0, w_ready}, 0);
    chk("abort_r_ready", {31'd0, r_ready}, 0);
    repeat (2) begin
      @(negedge CLK);
      chk("abort_complete_rst", {31'd0, w_complete}, 0);
    end
    RSTN = 1'b1;
    repeat (L + 2) begin
      @(negedge CLK);
      chk("abort_no_complete", {31'd0, w_complete}, 0);
      chk("abort_no_valid", {31'd0, d_valid}, 0);
    end
    do_read(30'h30, 0);

    do_write(30'h0, 32'h0BAD_0000, 1'b1);
    do_read(30'h400, 0);
    do_write(30'h401, 32'h7777_1111, 1'b1);
    do_read(30'h1, 1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = 30'($urandom_range(0, 1023));
        if ($urandom_range(0, 4) == 0) a = a | (30'($urandom_range(1, 255)) << DLG);
        do_write(a, $urandom, ($urandom_range(0, 3) != 0));
      end else begin
        a = written_q[$urandom_range(0, written_q.size() - 1)];
        if ($urandom_range(0, 3) == 0) a = a ^ (30'($urandom_range(1, 255)) << DLG);
        do_read(a, $urandom_range(0, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
